// File: rtl/free_list_ctrl_if.sv
// Rename-stage free-list bus: dispatch allocation, retire reclaim and recovery reclaim.
// The master drives requests; the free list (slave) returns the allocated PR and status.
interface free_list_ctrl_if #(
  parameter int unsigned PR_W = 6
);
  logic            alloc_req;
  logic            hazard_stall;
  logic [PR_W-1:0] p_rd_new;
  logic            free_empty;
  logic            retire;
  logic            RegDest_retire;
  logic [PR_W-1:0] PR_old_retire;
  logic            recover;
  logic            RegDest_ROB;
  logic [PR_W-1:0] p_rd_flush;
  logic [PR_W-1:0] free_cnt;
  logic            overflow_err;

  modport master (
    output alloc_req, hazard_stall, retire, RegDest_retire, PR_old_retire,
           recover, RegDest_ROB, p_rd_flush,
    input  p_rd_new, free_empty, free_cnt, overflow_err
  );

  modport slave (
    input  alloc_req, hazard_stall, retire, RegDest_retire, PR_old_retire,
           recover, RegDest_ROB, p_rd_flush,
    output p_rd_new, free_empty, free_cnt, overflow_err
  );
endinterface

// File: rtl/free_list_ctrl.sv
// Physical-register free list: circular FIFO of free PR numbers with one pop
// (dispatch) and up to two pushes (retire, recovery) per cycle.
module free_list_ctrl #(
  parameter int unsigned NUM_PR = 64,
  parameter int unsigned NUM_LR = 32,
  parameter int unsigned PR_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  free_list_ctrl_if.slave fl
);

  localparam int unsigned DEPTH = NUM_PR - NUM_LR;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PR_W;

  logic [PR_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             empty_q;
  logic             overflow_q;

  logic             pop;
  logic             ret_req, flush_req;
  logic             ret_ok, flush_ok;
  logic             ovf_set;
  logic [CNT_W:0]   room;
  logic [PTR_W-1:0] flush_addr;
  logic [PTR_W-1:0] tail_next;
  logic [CNT_W-1:0] count_next;

  // Push/pop qualification; room counts the slot freed by a same-cycle pop.
  always_comb begin
    pop        = fl.alloc_req & ~fl.hazard_stall & ~fl.recover & ~empty_q;
    ret_req    = fl.retire & fl.RegDest_retire & (fl.PR_old_retire != '0);
    flush_req  = fl.recover & fl.RegDest_ROB & (fl.p_rd_flush != '0);
    room       = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(pop);
    ret_ok     = ret_req & (room != '0);
    flush_ok   = flush_req & (room > (CNT_W+1)'(ret_ok));
    ovf_set    = (ret_req & ~ret_ok) | (flush_req & ~flush_ok);
    flush_addr = tail_q + PTR_W'(ret_ok);
    tail_next  = tail_q + PTR_W'(ret_ok) + PTR_W'(flush_ok);
    count_next = count_q + CNT_W'(ret_ok) + CNT_W'(flush_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PR_W'(NUM_LR + i);
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNT_W'(DEPTH);
      empty_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (ret_ok)   mem[tail_q]     <= fl.PR_old_retire;
      if (flush_ok) mem[flush_addr] <= fl.p_rd_flush;
      if (pop)      head_q          <= head_q + PTR_W'(1);
      tail_q     <= tail_next;
      count_q    <= count_next;
      empty_q    <= (count_next == '0);
      overflow_q <= overflow_q | ovf_set;
    end
  end

  // Offered PR is a read of the head slot; map_table samples it on the pop edge.
  assign fl.p_rd_new     = mem[head_q];
  assign fl.free_empty   = empty_q;
  assign fl.free_cnt     = count_q;
  assign fl.overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl: allocation, stall, retire/recovery reclaim,
// drain to empty, wrap-around ordering, overflow and PR0 filtering.
module tb_free_list_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  free_list_ctrl_if #(.PR_W(6)) fl ();

  free_list_ctrl #(.NUM_PR(64), .NUM_LR(32), .PR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    fl.alloc_req      = 1'b0;
    fl.hazard_stall   = 1'b0;
    fl.retire         = 1'b0;
    fl.RegDest_retire = 1'b0;
    fl.PR_old_retire  = '0;
    fl.recover        = 1'b0;
    fl.RegDest_ROB    = 1'b0;
    fl.p_rd_flush     = '0;
  endtask

  // Advance one clock; inputs and checks both sit 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    check("rst_cnt", 32'(fl.free_cnt), 32'd32);
    check("rst_prd", 32'(fl.p_rd_new), 32'h20);
    check("rst_empty", 32'(fl.free_empty), 32'd0);
    check("rst_ovf", 32'(fl.overflow_err), 32'd0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    step();
    step();
    do_reset();

    // Allocate three, then a stalled request
    fl.alloc_req = 1'b1;
    step(); check("alloc1_prd", 32'(fl.p_rd_new), 32'h21);
    step(); check("alloc2_prd", 32'(fl.p_rd_new), 32'h22);
    step(); check("alloc3_prd", 32'(fl.p_rd_new), 32'h23);
    check("alloc3_cnt", 32'(fl.free_cnt), 32'd29);
    fl.hazard_stall = 1'b1;
    step();
    check("stall_prd", 32'(fl.p_rd_new), 32'h23);
    check("stall_cnt", 32'(fl.free_cnt), 32'd29);

    // Retire 0x03 with concurrent alloc: mem[0]=0x03, head=4
    fl.hazard_stall   = 1'b0;
    fl.retire         = 1'b1;
    fl.RegDest_retire = 1'b1;
    fl.PR_old_retire  = 6'h03;
    step();
    check("ret_alloc_cnt", 32'(fl.free_cnt), 32'd29);
    check("ret_alloc_prd", 32'(fl.p_rd_new), 32'h24);

    // Recovery flush of 0x25 blocks the alloc
    idle();
    fl.alloc_req   = 1'b1;
    fl.recover     = 1'b1;
    fl.RegDest_ROB = 1'b1;
    fl.p_rd_flush  = 6'h25;
    step();
    check("flush_cnt", 32'(fl.free_cnt), 32'd30);
    check("flush_prd", 32'(fl.p_rd_new), 32'h24);
    fl.RegDest_ROB = 1'b0;
    step();
    check("flush_nodest_cnt", 32'(fl.free_cnt), 32'd30);

    // Retire 0x07 and flush 0x08 together
    fl.RegDest_ROB    = 1'b1;
    fl.p_rd_flush     = 6'h08;
    fl.retire         = 1'b1;
    fl.RegDest_retire = 1'b1;
    fl.PR_old_retire  = 6'h07;
    step();
    check("dual_push_cnt", 32'(fl.free_cnt), 32'd32);
    check("dual_push_ovf", 32'(fl.overflow_err), 32'd0);

    // Drain head 4..31, then the wrapped entries must come out in push order
    idle();
    fl.alloc_req = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      step();
      check("drain_prd", 32'(fl.p_rd_new), 32'h24 + 32'(k));
    end
    step(); check("wrap0_prd", 32'(fl.p_rd_new), 32'h03);
    check("wrap0_cnt", 32'(fl.free_cnt), 32'd4);
    step(); check("wrap1_prd", 32'(fl.p_rd_new), 32'h25);
    step(); check("wrap2_prd", 32'(fl.p_rd_new), 32'h07);
    step(); check("wrap3_prd", 32'(fl.p_rd_new), 32'h08);
    check("wrap3_cnt", 32'(fl.free_cnt), 32'd1);
    step();
    check("drain_empty", 32'(fl.free_empty), 32'd1);
    check("drain_cnt", 32'(fl.free_cnt), 32'd0);

    // Drain to empty from a fresh reset asserted between edges
    do_reset();
    fl.alloc_req = 1'b1;
    for (int k = 0; k < 32; k++) step();
    check("empty_flag", 32'(fl.free_empty), 32'd1);
    check("empty_cnt", 32'(fl.free_cnt), 32'd0);
    step();
    step();
    check("empty_hold_prd", 32'(fl.p_rd_new), 32'h20);
    check("empty_hold_cnt", 32'(fl.free_cnt), 32'd0);
    idle();
    fl.retire         = 1'b1;
    fl.RegDest_retire = 1'b1;
    fl.PR_old_retire  = 6'h05;
    step();
    check("refill_empty", 32'(fl.free_empty), 32'd0);
    check("refill_prd", 32'(fl.p_rd_new), 32'h05);
    check("refill_cnt", 32'(fl.free_cnt), 32'd1);

    // Overflow from full, then PR0 filter, then confirm tail did not move
    do_reset();
    fl.retire         = 1'b1;
    fl.RegDest_retire = 1'b1;
    fl.PR_old_retire  = 6'h10;
    step();
    check("ovf_flag", 32'(fl.overflow_err), 32'd1);
    check("ovf_cnt", 32'(fl.free_cnt), 32'd32);
    idle();
    fl.alloc_req = 1'b1;
    step();
    check("ovf_alloc_cnt", 32'(fl.free_cnt), 32'd31);
    idle();
    fl.retire         = 1'b1;
    fl.RegDest_retire = 1'b1;
    fl.PR_old_retire  = 6'h00;
    step();
    check("zero_cnt", 32'(fl.free_cnt), 32'd31);
    check("ovf_sticky", 32'(fl.overflow_err), 32'd1);
    fl.PR_old_retire = 6'h11;
    step();
    check("ovf_refill_cnt", 32'(fl.free_cnt), 32'd32);
    idle();
    fl.alloc_req = 1'b1;
    for (int k = 0; k < 31; k++) step();
    check("tail_hold_prd", 32'(fl.p_rd_new), 32'h11);
    check("tail_hold_cnt", 32'(fl.free_cnt), 32'd1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/free_list_ctrl.md
Name: free_list_ctrl

Overview:
- Physical-register free list and allocator for the OoO rename stage.
- Supplies the new physical destination (p_rd_new) to map_table at dispatch.
- Reclaims the previous mapping (PR_old_rd) when an instruction retires from the ROB, and reclaims squashed destinations during ROB recovery.
- Storage is a circular FIFO of the free physical register numbers.
- Drives free_empty to the hazard unit so dispatch stalls when no register is available.

Parameters:
- NUM_PR, 64, number of physical registers.
- NUM_LR, 32, number of logical registers; PR 0..NUM_LR-1 are the reset identity mappings.
- PR_W, 6, physical register index width (log2 NUM_PR).
- DEPTH, NUM_PR-NUM_LR = 32, free FIFO depth.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req  in  1  dispatching instruction writes a register (dispatch RegDest).
- hazard_stall  in  1  dispatch is stalled this cycle.
- p_rd_new  out  PR_W  physical register offered to map_table (mem[head]).
- free_empty  out  1  no free physical register; feeds the hazard unit.
- retire  in  1  ROB head retiring this cycle.
- RegDest_retire  in  1  retiring instruction had a destination.
- PR_old_retire  in  PR_W  previous mapping of the retiring rd, to be freed.
- recover  in  1  ROB recovery walk active; one squashed entry per cycle.
- RegDest_ROB  in  1  squashed entry had a destination.
- p_rd_flush  in  PR_W  squashed entry's physical register, to be freed.
- free_cnt  out  PR_W  number of free entries, 0..DEPTH.
- overflow_err  out  1  sticky: a push was attempted while the list was full.

Behaviour:
- Reset, asynchronous, immediate on rst=1, including mid-operation:
  - mem[i] = NUM_LR+i for i = 0..31; head = 0; tail = 0 (5-bit pointers, wrap mod 32).
  - count = 32; free_cnt = 32; free_empty = 0; overflow_err = 0; p_rd_new = 0x20.
- p_rd_new = mem[head], combinational. map_table samples it at the same posedge as the pop.
- Pop (alloc) fires when alloc_req & ~hazard_stall & ~recover & ~free_empty; it advances head by 1.
- Retire push fires when retire & RegDest_retire & (PR_old_retire != 0): mem[tail] <= PR_old_retire.
- Flush push fires when recover & RegDest_ROB & (p_rd_flush != 0). It writes mem[tail + retire_push] and advances tail by the total number of pushes.
- PR 0 is permanently bound to $zero and is never pushed.
- Up to two pushes and one pop may occur in the same cycle:
  - count_next = count + pushes - pop.
  - A pop reads the pre-update head, so an entry pushed this cycle cannot be popped this cycle (no bypass).
- Full: any push that would make count exceed DEPTH is dropped (no write, no tail advance) and sets overflow_err. overflow_err stays set until rst.
- Empty: free_empty = (count == 0).
  - An alloc_req while empty does not pop; p_rd_new holds the stale value and the hazard unit must stall dispatch.
  - free_empty deasserts the cycle after any push.
- During recover no pop occurs, even if alloc_req=1.
- free_cnt = count, registered.
- No other states; the controller is pointer/counter sequenced.

Test Plan:
- Reset check: pulse rst between clock edges → outputs change immediately to free_cnt=32, p_rd_new=0x20, free_empty=0, overflow_err=0.
- Allocate and stall:
  - alloc_req=1 for 3 cycles → p_rd_new steps 0x20, 0x21, 0x22 → 0x23; free_cnt=29.
  - Then alloc_req=1 with hazard_stall=1 → p_rd_new stays 0x23, free_cnt stays 29.
- Retire with concurrent alloc: retire=1, RegDest_retire=1, PR_old_retire=0x03, alloc_req=1 → mem[0]=0x03, head=4, free_cnt stays 29.
- Recovery:
  - recover=1, RegDest_ROB=1, p_rd_flush=0x25, alloc_req=1 → no pop, free_cnt 29→30.
  - Next cycle recover=1, RegDest_ROB=0 → free_cnt stays 30.
  - recover=1 plus retire push in the same cycle → both written in order retire then flush, free_cnt +2.
- Drain to empty: from reset, 32 allocs → free_empty=1, free_cnt=0; further alloc_req leaves head unchanged. Then retire 0x05 → next cycle free_empty=0, p_rd_new=0x05, free_cnt=1.
- Overflow and zero filter:
  - From reset, retire PR_old_retire=0x10 → overflow_err=1, free_cnt stays 32, tail unchanged.
  - Retire PR_old_retire=0x00 with RegDest_retire=1 → ignored, no count change.
